// File: rtl/acq_sequencer.sv
// Code-phase acquisition controller: sweeps the C/A generator through every phase,
// correlates against the mixed baseband bit and keeps the strongest phase.
module acq_sequencer #(
  parameter int CHIP_DIV = 16,
  parameter int CODE_LEN = 1023,
  parameter int CNT_W    = 10,
  parameter int PH_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       prn_t0,
  input  logic [3:0]       prn_t1,
  input  logic [CNT_W-1:0] threshold,
  input  logic             sig_in,
  input  logic             code_in,
  output logic             ca_en,
  output logic             ca_rst,
  output logic [3:0]       ca_t0,
  output logic [3:0]       ca_t1,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             cfg_err,
  output logic [PH_W-1:0]  best_phase,
  output logic [CNT_W-1:0] best_count
);

  localparam int DIV_W = (CHIP_DIV > 2) ? $clog2(CHIP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHIP_DIV - 1);
  localparam logic [CNT_W-1:0] CHIP_LAST = CNT_W'(CODE_LEN - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'((CODE_LEN + 1) / 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_EVAL, S_SLIP, S_DONE} state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] chip_cnt;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] thr_q;
  logic             chip_stb;
  logic             cfg_valid;
  logic             start_ok;
  logic             start_bad;
  logic             agree;
  logic [CNT_W-1:0] metric;
  logic [CNT_W-1:0] best_next;
  logic             better;

  function automatic logic tap_ok(input logic [3:0] t);
    return (t != 4'd0) && (t <= 4'd10);
  endfunction

  // A full inversion (data bit flipped) correlates as strongly as a match.
  function automatic logic [CNT_W-1:0] fold_metric(input logic [CNT_W-1:0] a);
    return (a >= HALF_C) ? a : (LEN_C - a);
  endfunction

  assign cfg_valid = tap_ok(prn_t0) && tap_ok(prn_t1) && (prn_t0 != prn_t1);
  assign chip_stb  = ((state == S_RUN) || (state == S_SLIP)) && (div == DIV_LAST);
  assign agree     = ~(sig_in ^ code_in);
  assign metric    = fold_metric(acc);
  assign better    = (metric > best_count);
  assign best_next = better ? metric : best_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    ca_rst    = (state == S_LOAD);
    ca_en     = (state == S_RUN) && chip_stb && !abort;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_valid) begin
            start_ok = 1'b1;
            state_d  = S_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (chip_stb && (chip_cnt == CHIP_LAST)) state_d = S_EVAL;
      S_EVAL: state_d = (phase == PH_LAST) ? S_DONE : S_SLIP;
      S_SLIP: if (chip_stb) state_d = S_RUN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      start_ok  = 1'b0;
      start_bad = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      chip_cnt   <= '0;
      phase      <= '0;
      acc        <= '0;
      thr_q      <= '0;
      ca_t0      <= '0;
      ca_t1      <= '0;
      best_phase <= '0;
      best_count <= '0;
      found      <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (abort) begin
      div      <= '0;
      chip_cnt <= '0;
      phase    <= '0;
      acc      <= '0;
      found    <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= start_bad;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            ca_t0      <= prn_t0;
            ca_t1      <= prn_t1;
            thr_q      <= threshold;
            best_phase <= '0;
            best_count <= '0;
            found      <= 1'b0;
          end
        end
        S_LOAD: begin
          div      <= '0;
          chip_cnt <= '0;
          phase    <= '0;
          acc      <= '0;
        end
        // Sample on the strobe cycle, before cagen advances on the same edge.
        S_RUN: begin
          div <= chip_stb ? '0 : div + DIV_W'(1);
          if (chip_stb) begin
            acc      <= acc + CNT_W'(agree);
            chip_cnt <= chip_cnt + CNT_W'(1);
          end
        end
        S_EVAL: begin
          div <= '0;
          if (better) begin
            best_count <= metric;
            best_phase <= phase;
          end
          if (phase == PH_LAST) begin
            found <= (best_next >= thr_q);
          end else begin
            phase    <= phase + PH_W'(1);
            acc      <= '0;
            chip_cnt <= '0;
          end
        end
        S_SLIP: div <= chip_stb ? '0 : div + DIV_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer using a short 31-chip m-sequence as the code,
// with a behavioural code generator and a delayed/inverted/noise signal source.
module tb_acq_sequencer;
  localparam int CD = 2;
  localparam int L  = 31;
  localparam int CW = 5;
  localparam int PW = 5;
  localparam int SEARCH_CYC = 2015;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    prn_t0 = 4'd0;
  logic [3:0]    prn_t1 = 4'd0;
  logic [CW-1:0] threshold = '0;
  logic          sig_in;
  logic          code_in;
  logic          ca_en, ca_rst, busy, done, found, cfg_err;
  logic [3:0]    ca_t0, ca_t1;
  logic [PW-1:0] best_phase;
  logic [CW-1:0] best_count;

  int checks = 0;
  int errors = 0;

  bit seq[L];
  bit noise_tab[1200];
  int code_idx = 0;
  int sig_idx = 0;
  int en_cnt = 0;
  int delay = 0;
  bit inv = 1'b0;
  bit use_noise = 1'b0;

  acq_sequencer #(.CHIP_DIV(CD), .CODE_LEN(L), .CNT_W(CW), .PH_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prn_t0(prn_t0), .prn_t1(prn_t1), .threshold(threshold),
    .sig_in(sig_in), .code_in(code_in),
    .ca_en(ca_en), .ca_rst(ca_rst), .ca_t0(ca_t0), .ca_t1(ca_t1),
    .busy(busy), .done(done), .found(found), .cfg_err(cfg_err),
    .best_phase(best_phase), .best_count(best_count)
  );

  always #5 clk = ~clk;

  // Code generator stand-in; the signal source skips one extra chip per window
  // so it keeps running while the code generator is held during the slip.
  always @(posedge clk) begin
    if (ca_rst) begin
      code_idx <= 0;
      sig_idx  <= 0;
      en_cnt   <= 0;
    end else if (ca_en) begin
      code_idx <= (code_idx + 1) % L;
      if (en_cnt == L - 1) begin
        en_cnt  <= 0;
        sig_idx <= sig_idx + 2;
      end else begin
        en_cnt  <= en_cnt + 1;
        sig_idx <= sig_idx + 1;
      end
    end
  end

  always_comb begin
    code_in = seq[code_idx];
    if (use_noise) sig_in = noise_tab[sig_idx];
    else           sig_in = seq[(sig_idx + L * L - delay) % L] ^ inv;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [3:0] a, input logic [3:0] b, input logic [CW-1:0] thr);
    @(negedge clk);
    prn_t0 = a;
    prn_t1 = b;
    threshold = thr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int cyc_in, input int maxc, output int cyc);
    cyc = cyc_in;
    while (done !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic model_best(output int bp, output int bc);
    int acc, m, idx;
    bit s;
    bp = 0;
    bc = 0;
    for (int p = 0; p < L; p++) begin
      acc = 0;
      for (int k = 0; k < L; k++) begin
        idx = p * (L + 1) + k;
        s = use_noise ? noise_tab[idx] : (seq[(idx + L * L - delay) % L] ^ inv);
        if (s == seq[k]) acc++;
      end
      m = (acc >= (L + 1) / 2) ? acc : L - acc;
      if (m > bc) begin
        bc = m;
        bp = p;
      end
    end
  endtask

  task automatic full_search(input string tag, input int exp_ph, input int exp_cnt, input bit exp_found);
    int cyc;
    kick(4'd2, 4'd6, CW'(28));
    chk({tag, "_load_carst"}, ca_rst, 1);
    chk({tag, "_load_busy"}, busy, 1);
    wait_done(1, 4000, cyc);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cycles"}, cyc, SEARCH_CYC);
    chk({tag, "_phase"}, best_phase, exp_ph);
    chk({tag, "_count"}, best_count, exp_cnt);
    chk({tag, "_found"}, found, exp_found);
    @(negedge clk);
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold_count"}, best_count, exp_cnt);
  endtask

  initial begin
    int cyc, bp, bc, quiet_bad;

    for (int n = 0; n < L; n++) seq[n] = (n < 5) ? 1'b1 : (seq[n-3] ^ seq[n-5]);
    for (int n = 0; n < 1200; n++) noise_tab[n] = (n < 7) ? 1'b1 : (noise_tab[n-1] ^ noise_tab[n-7]);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ca_en", ca_en, 0);
    chk("rst_ca_rst", ca_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_best_phase", best_phase, 0);
    chk("rst_best_count", best_count, 0);
    chk("rst_ca_t0", ca_t0, 0);
    chk("rst_ca_t1", ca_t1, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ca_rst", ca_rst, 0);

    // Rejected configurations
    kick(4'd5, 4'd5, CW'(28));
    chk("bad_same_cfg_err", cfg_err, 1);
    chk("bad_same_busy", busy, 0);
    chk("bad_same_ca_rst", ca_rst, 0);
    @(negedge clk);
    chk("bad_same_pulse_len", cfg_err, 0);
    chk("bad_same_ca_rst2", ca_rst, 0);
    kick(4'd0, 4'd3, CW'(28));
    chk("bad_zero_cfg_err", cfg_err, 1);
    kick(4'd3, 4'd11, CW'(28));
    chk("bad_big_cfg_err", cfg_err, 1);
    chk("bad_big_busy", busy, 0);
    chk("bad_no_latch", ca_t0, 0);

    // Aligned code, delay 7, with an ignored start while busy
    delay = 7; inv = 1'b0; use_noise = 1'b0;
    kick(4'd2, 4'd6, CW'(28));
    chk("al_load_carst", ca_rst, 1);
    chk("al_ca_t0", ca_t0, 2);
    chk("al_ca_t1", ca_t1, 6);
    prn_t0 = 4'd5; prn_t1 = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("al_busy_start_no_err", cfg_err, 0);
    chk("al_busy_start_busy", busy, 1);
    chk("al_taps_kept", ca_t0, 2);
    wait_done(3, 4000, cyc);
    chk("al_done", done, 1);
    chk("al_cycles", cyc, SEARCH_CYC);
    chk("al_phase", best_phase, 7);
    chk("al_count", best_count, 31);
    chk("al_found", found, 1);
    @(negedge clk);
    chk("al_busy_drop", busy, 0);
    chk("al_done_pulse", done, 0);
    chk("al_found_hold", found, 1);

    // Inverted data
    delay = 5; inv = 1'b1;
    full_search("inv", 5, 31, 1'b1);

    // Uncorrelated noise
    use_noise = 1'b1; inv = 1'b0;
    model_best(bp, bc);
    full_search("noise", bp, bc, 1'b0);

    // Abort during the slip that follows phase 9's evaluation
    use_noise = 1'b0; delay = 20;
    kick(4'd2, 4'd6, CW'(28));
    cyc = 1;
    while (cyc < 650) begin
      @(negedge clk);
      cyc++;
    end
    chk("ab_busy_before", busy, 1);
    chk("ab_ca_en_before", ca_en, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy_after", busy, 0);
    chk("ab_done_after", done, 0);
    chk("ab_ca_en_after", ca_en, 0);
    chk("ab_partial_count", best_count, 16);
    chk("ab_partial_phase", best_phase, 0);
    chk("ab_found", found, 0);
    quiet_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || ca_en !== 1'b0) quiet_bad++;
    end
    chk("ab_quiet", quiet_bad, 0);

    full_search("restart", 20, 31, 1'b1);

    // Reset in the middle of RUN
    delay = 3;
    kick(4'd2, 4'd6, CW'(28));
    repeat (40) @(negedge clk);
    chk("mr_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_ca_en", ca_en, 0);
    chk("mr_ca_t0", ca_t0, 0);
    chk("mr_count", best_count, 0);
    @(negedge clk);
    chk("mr_done", done, 0);
    chk("mr_found", found, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_idle_busy", busy, 0);
    chk("mr_idle_ca_rst", ca_rst, 0);
    chk("mr_idle_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Code-phase acquisition controller for one satellite PRN.
- Configures and steps the C/A code generator (`cagen`) through all 1023 code phases.
- Correlates the generated code against the mixed baseband bit from `xor_mixer` and reports the best phase and correlation magnitude to the top level.
- Sits between the SPI/button control and the `cagen`/mixer datapath.

Parameters:
- CHIP_DIV, 16, clk cycles per code chip (≥2).
- CODE_LEN, 1023, chips per code period; also the number of phases searched.
- CNT_W, 10, width of the correlation counters; must hold CODE_LEN.
- PH_W, 10, width of the phase counter; must hold CODE_LEN-1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that starts a search; ignored unless in IDLE.
- abort, in, 1: returns to IDLE from any state; no done pulse.
- prn_t0, in, 4: G2 tap select 1..10, latched at start.
- prn_t1, in, 4: G2 tap select 1..10, latched at start.
- threshold, in, CNT_W: detection threshold, latched at start.
- sig_in, in, 1: mixed signal bit.
- code_in, in, 1: current chip from `cagen`.
- ca_en, out, 1: `cagen` advance enable, one-cycle strobe.
- ca_rst, out, 1: `cagen` reset, active-high.
- ca_t0, out, 4: latched tap to `cagen`.
- ca_t1, out, 4: latched tap to `cagen`.
- busy, out, 1: high from LOAD through DONE.
- done, out, 1: one-cycle pulse at search completion.
- found, out, 1: best_count ≥ threshold, valid from done.
- cfg_err, out, 1: one-cycle pulse on rejected start.
- best_phase, out, PH_W: phase index of the best correlation.
- best_count, out, CNT_W: best correlation metric.

Behaviour:
- Reset (rst=0) values:
  - Outputs: all 0; ca_t0 = ca_t1 = 0.
  - Internal: state = IDLE; divider, chip, phase and accumulator counters = 0.
- Start validation: start in IDLE checks the taps.
  - Invalid when t0 or t1 is 0, either is >10, or t0==t1.
  - Invalid start: pulse cfg_err for 1 cycle, stay in IDLE, leave results untouched.
  - Valid start: latch taps and threshold; clear best_phase and best_count; go to LOAD.
- LOAD (1 cycle):
  - ca_rst=1; divider=0, chip_cnt=0, phase=0, acc=0.
  - Next state: RUN.
- Chip strobe:
  - The divider counts 0..CHIP_DIV-1 and wraps in RUN and SLIP.
  - chip_stb = (divider == CHIP_DIV-1).
- RUN:
  - ca_en = chip_stb.
  - On chip_stb: sample (sig_in XOR code_in) in the same cycle, before `cagen` advances.
  - acc += 1 when the XOR is 0 (agreement); chip_cnt increments.
  - When chip_stb occurs with chip_cnt == CODE_LEN-1: go to EVAL; divider is held at 0.
- EVAL (1 cycle):
  - metric = acc when acc ≥ ceil(CODE_LEN/2), else CODE_LEN-acc. This tolerates a data-bit inversion.
  - When metric > best_count (strict, so the earliest phase wins ties): best_count = metric, best_phase = phase.
  - When phase == CODE_LEN-1: go to DONE.
  - Otherwise: phase+1, acc=0, chip_cnt=0, go to SLIP.
- SLIP:
  - Lasts exactly CHIP_DIV cycles with ca_en held 0. The code slips one chip late relative to sig_in.
  - Then go to RUN with the divider at 0.
- DONE (1 cycle):
  - done=1; found = (best_count ≥ threshold).
  - Next state: IDLE; busy drops the following cycle.
- Result hold: best_phase, best_count and found hold until the next valid start or reset.
- busy: asserted in LOAD, RUN, EVAL, SLIP and DONE.
- abort:
  - Has priority over all transitions: next state is IDLE.
  - ca_en=0; counters cleared; results keep their partial values; found=0.
- start while busy: ignored; no cfg_err.
- Reset mid-search: immediate return to the reset state; no done pulse.
- Search length: CODE_LEN windows. Each window is CODE_LEN·CHIP_DIV cycles + 1 EVAL cycle + CHIP_DIV slip cycles; the final window has no slip.
- Arithmetic:
  - All counters are unsigned.
  - acc never exceeds CODE_LEN, so no wrap occurs.
  - phase never wraps during a search.

Test Plan:
- Reset: hold rst=0 mid-RUN with CHIP_DIV=2 → all outputs 0 and state IDLE on the next clk edge; release → no activity until start.
- Bad config: start with t0=5, t1=5 → cfg_err pulses 1 cycle, busy stays 0, ca_rst never asserted.
- Aligned code: CHIP_DIV=2, PRN1 (taps 2,6); sig_in = reference `cagen` output delayed by 100 chips; threshold=900.
  - Required: done after the full sweep, best_phase=100, best_count=1023, found=1.
- Inverted data: same as the aligned-code case with sig_in inverted → best_phase=100, best_count=1023, found=1.
- Noise: sig_in from an LFSR uncorrelated with the code, threshold=900 → done pulses, found=0, best_count<600.
- Abort: assert abort during SLIP of phase 10 → busy=0 the next cycle, no done pulse, ca_en stays 0.
  - Required: a subsequent valid start runs the full sweep normally.
